// File: rtl/data_mem_responder_if.sv
// Request/response bus between an initiator and data_mem_responder.
// Signals: req_valid/req_ready request handshake; Address, WriteData,
// MemWrite and MemRead describe the request; resp_valid is a one-cycle
// response strobe qualifying ReadData and access_err.
interface data_mem_responder_if;
  localparam int unsigned DATA_W = 32;

  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] Address;
  logic [DATA_W-1:0] WriteData;
  logic              MemWrite;
  logic              MemRead;
  logic              resp_valid;
  logic [DATA_W-1:0] ReadData;
  logic              access_err;

  modport master (
    output req_valid, Address, WriteData, MemWrite, MemRead,
    input  req_ready, resp_valid, ReadData, access_err
  );

  modport slave (
    input  req_valid, Address, WriteData, MemWrite, MemRead,
    output req_ready, resp_valid, ReadData, access_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a fixed-latency request/response protocol.
// Ports: clk (rising edge), reset (synchronous, active-high), bus (slave
// modport of data_mem_responder_if). Each accepted request waits WAIT_CYCLES
// cycles, then commits the access and strobes resp_valid for one cycle.
// Misaligned, out-of-range and read+write requests return access_err=1.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                req_ready_q, req_ready_d;

  logic [DATA_W-1:0]   mem [DEPTH_WORDS];

  // Access operands for the commit edge; bypass the latches when there is no wait.
  logic                commit;
  logic [DATA_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;
  logic                acc_rd;
  logic                acc_wr;
  logic [IDX_W-1:0]    acc_idx;
  logic                acc_err;
  logic                mem_we;

  // Next-state, request latching and response computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    resp_valid_d = 1'b0;
    rdata_d      = rdata_q;
    err_d        = err_q;
    commit       = 1'b0;
    acc_addr     = addr_q;
    acc_wdata    = wdata_q;
    acc_rd       = rd_q;
    acc_wr       = wr_q;
    mem_we       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && (bus.MemRead || bus.MemWrite)) begin
          addr_d  = bus.Address;
          wdata_d = bus.WriteData;
          rd_d    = bus.MemRead;
          wr_d    = bus.MemWrite;
          if (WAIT_CYCLES == 0) begin
            state_d   = RESP;
            commit    = 1'b1;
            acc_addr  = bus.Address;
            acc_wdata = bus.WriteData;
            acc_rd    = bus.MemRead;
            acc_wr    = bus.MemWrite;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    acc_idx = acc_addr[IDX_W+1:2];
    acc_err = (acc_addr[1:0] != 2'b00) ||
              (acc_addr[DATA_W-1:IDX_W+2] != '0) ||
              (acc_rd && acc_wr);

    if (commit) begin
      resp_valid_d = 1'b1;
      err_d        = acc_err;
      rdata_d      = (!acc_err && acc_rd) ? mem[acc_idx] : '0;
      mem_we       = !acc_err && acc_wr;
    end

    req_ready_d = (state_d == IDLE);
  end

  // Control and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
    end
  end

  // Storage array; contents survive reset, but a commit coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.ReadData   = rdata_q;
  assign bus.access_err = err_q;
endmodule
